// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of it: 1 start bit, 5..8 data bits LSB first,
// 1 stop bit. Bit timing comes from rising edges of an external 16x-baud tick square wave.
module uart_tx_fifo #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             tx_en,
    input  logic [3:0]       nbits,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CntFull  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic             tick_q;
    logic             tick_rise;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             push, pop;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [3:0]       nbits_q, nbits_d;
    logic [3:0]       nbits_eff;
    logic [7:0]       shift_q, shift_d;
    logic             tx_done_q, tx_done_d;

    assign tick_rise  = tick & ~tick_q;
    assign full       = (count_q == CntFull);
    assign empty      = (count_q == '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    // Full is judged before the edge, so a pop in the same cycle does not make room.
    assign push       = wr_en & ~full;
    assign nbits_eff  = (nbits >= 4'd5 && nbits <= 4'd8) ? nbits : 4'd8;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            tick_q     <= tick;
            overflow_q <= wr_en & full;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            nbits_q    <= 4'd8;
            shift_q    <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            nbits_q    <= nbits_d;
            shift_q    <= shift_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        nbits_d    = nbits_q;
        shift_d    = shift_q;
        tx_done_d  = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_en && !empty) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    nbits_d    = nbits_eff;
                    tick_cnt_d = '0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (tick_rise) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick_rise) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        if ({1'b0, bit_idx_q} == nbits_q - 4'd1) begin
                            state_d = StStop;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (tick_rise) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        tx_done_d  = 1'b1;
                        // Back-to-back: next start bit begins right at the end of this stop bit.
                        if (tx_en && !empty) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            nbits_d = nbits_eff;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        unique case (state_q)
            StStart: tx = 1'b0;
            StData:  tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign tx_done = tx_done_q;

endmodule
